// File: rtl/baccarat_datapath_if.sv
// Controller <-> card/score datapath bundle: load strobes toward the datapath, card/score/display results back.
interface baccarat_datapath_if;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic [3:0] pcard3_out;
  logic [3:0] pscore_out;
  logic [3:0] dscore_out;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    input  pcard3_out, pscore_out, dscore_out,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    output pcard3_out, pscore_out, dscore_out,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/baccarat_datapath.sv
// Baccarat card/score datapath: card source, six card registers, hand scores and 7-seg decode.
// Define BACCARAT_LFSR_DEAL_EN to replace the wrapping counter card source with an 8-bit LFSR.
module baccarat_datapath #(
  parameter logic [3:0] DEAL_START = 4'd1
) (
  input  logic                 slow_clock,
  input  logic                 resetb,
  baccarat_datapath_if.slave   dp
);

  logic [3:0] deal_card;
  logic [5:0] load_vec;
  logic [3:0] card_q [6];
  logic [3:0] card_d [6];

  function automatic logic [4:0] card_points(input logic [3:0] c);
    card_points = (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] c0, input logic [3:0] c1,
                                            input logic [3:0] c2);
    logic [4:0] sum;
    logic [4:0] rem;
    sum = card_points(c0) + card_points(c1) + card_points(c2);
    rem = sum % 5'd10;
    hand_score = rem[3:0];
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'd1:    seg7 = 7'b0001000;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      4'd10:   seg7 = 7'b1000000;
      4'd11:   seg7 = 7'b1100001;
      4'd12:   seg7 = 7'b0011000;
      4'd13:   seg7 = 7'b0001001;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

`ifdef BACCARAT_LFSR_DEAL_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [7:0] lfsr_mod;

  // Taps for x^8+x^6+x^5+x^4+1
  always_comb begin
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    lfsr_mod  = lfsr_q % 8'd13;
    deal_card = lfsr_mod[3:0] + 4'd1;
  end

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) lfsr_q <= 8'h01;
    else        lfsr_q <= lfsr_d;
  end
`else
  logic [3:0] deal_q;
  logic [3:0] deal_d;

  always_comb begin
    deal_d    = (deal_q == 4'd13) ? 4'd1 : deal_q + 4'd1;
    deal_card = deal_q;
  end

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) deal_q <= DEAL_START;
    else        deal_q <= deal_d;
  end
`endif

  assign load_vec = {dp.load_dcard3, dp.load_dcard2, dp.load_dcard1,
                     dp.load_pcard3, dp.load_pcard2, dp.load_pcard1};

  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      card_d[i] = card_q[i];
      if (load_vec[i]) card_d[i] = deal_card;
    end
  end

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) begin
      for (int unsigned i = 0; i < 6; i++) card_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 6; i++) card_q[i] <= card_d[i];
    end
  end

  always_comb begin
    dp.pcard3_out = card_q[2];
    dp.pscore_out = hand_score(card_q[0], card_q[1], card_q[2]);
    dp.dscore_out = hand_score(card_q[3], card_q[4], card_q[5]);
    dp.HEX0       = seg7(card_q[0]);
    dp.HEX1       = seg7(card_q[1]);
    dp.HEX2       = seg7(card_q[2]);
    dp.HEX3       = seg7(card_q[3]);
    dp.HEX4       = seg7(card_q[4]);
    dp.HEX5       = seg7(card_q[5]);
  end

endmodule

// File: tb/tb_baccarat_datapath.sv
// Scoreboard bench for baccarat_datapath (counter card source): expected outputs queued per edge.
module tb_baccarat_datapath;

  localparam logic [3:0] DEAL_START = 4'd1;

  typedef struct packed {
    logic [3:0]      pcard3;
    logic [3:0]      pscore;
    logic [3:0]      dscore;
    logic [5:0][6:0] hex;
  } exp_t;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;

  baccarat_datapath_if bus ();

  baccarat_datapath #(.DEAL_START(DEAL_START)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .dp         (bus)
  );

  always #5 slow_clock = ~slow_clock;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  int         m_deal;
  logic [3:0] m_card [6];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    logic [6:0] t [16];
    t = '{7'h7f, 7'b0001000, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
          7'b1111000, 7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001, 7'b0011000,
          7'b0001001, 7'h7f, 7'h7f};
    return t[c];
  endfunction

  function automatic int pts(input logic [3:0] c);
    return (c >= 1 && c <= 9) ? int'(c) : 0;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.pcard3 = m_card[2];
    e.pscore = 4'((pts(m_card[0]) + pts(m_card[1]) + pts(m_card[2])) % 10);
    e.dscore = 4'((pts(m_card[3]) + pts(m_card[4]) + pts(m_card[5])) % 10);
    for (int i = 0; i < 6; i++) e.hex[i] = ref_seg(m_card[i]);
    return e;
  endfunction

  task automatic model_reset();
    m_deal = int'(DEAL_START);
    for (int i = 0; i < 6; i++) m_card[i] = 4'd0;
  endtask

  task automatic compare_pop(input string ph);
    exp_t e;
    if (sb.size() == 0) begin
      check({ph, "_sb_empty"}, 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    check({ph, "_pcard3"}, {4'd0, bus.pcard3_out}, {4'd0, e.pcard3});
    check({ph, "_pscore"}, {4'd0, bus.pscore_out}, {4'd0, e.pscore});
    check({ph, "_dscore"}, {4'd0, bus.dscore_out}, {4'd0, e.dscore});
    check({ph, "_hex0"}, {1'b0, bus.HEX0}, {1'b0, e.hex[0]});
    check({ph, "_hex1"}, {1'b0, bus.HEX1}, {1'b0, e.hex[1]});
    check({ph, "_hex2"}, {1'b0, bus.HEX2}, {1'b0, e.hex[2]});
    check({ph, "_hex3"}, {1'b0, bus.HEX3}, {1'b0, e.hex[3]});
    check({ph, "_hex4"}, {1'b0, bus.HEX4}, {1'b0, e.hex[4]});
    check({ph, "_hex5"}, {1'b0, bus.HEX5}, {1'b0, e.hex[5]});
  endtask

  // loads bit order: p1,p2,p3,d1,d2,d3 from bit 0 upward
  task automatic step(input logic [5:0] loads, input logic rst, input string ph);
    @(negedge slow_clock);
    resetb          = rst;
    bus.load_pcard1 = loads[0];
    bus.load_pcard2 = loads[1];
    bus.load_pcard3 = loads[2];
    bus.load_dcard1 = loads[3];
    bus.load_dcard2 = loads[4];
    bus.load_dcard3 = loads[5];
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 6; i++) if (loads[i]) m_card[i] = 4'(m_deal);
      m_deal = (m_deal == 13) ? 1 : m_deal + 1;
    end
    sb.push_back(model_outputs());
    @(posedge slow_clock);
    #1;
    compare_pop(ph);
  endtask

  task automatic mid_reset();
    #2;
    resetb = 1'b1;
    model_reset();
    sb.push_back(model_outputs());
    #1;
    compare_pop("async_rst");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_pcard1 = 1'b0;
    bus.load_pcard2 = 1'b0;
    bus.load_pcard3 = 1'b0;
    bus.load_dcard1 = 1'b0;
    bus.load_dcard2 = 1'b0;
    bus.load_dcard3 = 1'b0;
    model_reset();

    step(6'b000000, 1'b1, "reset");
    step(6'b001001, 1'b0, "first_p1d1");
    repeat (2) step(6'b000000, 1'b0, "idle");
    step(6'b111111, 1'b0, "all_six_4");
    repeat (3) step(6'b000000, 1'b0, "idle");
    step(6'b000010, 1'b0, "p2_8");
    step(6'b000001, 1'b0, "p1_9");
    step(6'b010000, 1'b0, "d2_10");
    step(6'b001000, 1'b0, "d1_J");
    step(6'b010000, 1'b0, "d2_Q");
    step(6'b100100, 1'b0, "p3d3_K");
    step(6'b000001, 1'b0, "p1_wrap");

    repeat (30) step(6'($urandom_range(0, 63)), 1'b0, "rand");

    mid_reset();
    step(6'b111111, 1'b1, "rst_loads_ignored");
    repeat (13) step(6'b000000, 1'b0, "idle13");
    step(6'b000001, 1'b0, "wrap_to_start");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
